// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared state type, default length and index-width helper for the pattern generator.
package pattern_seq_pkg;
  typedef enum logic {IDLE, RUN} pat_state_t;
  localparam int DEFAULT_LEN = 8;
  function automatic int clog2_len(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction
endpackage

// File: rtl/seq_bit_counter.sv
// seq_bit_counter: modulo-LEN bit index counter with clear, enable and terminal count.
module seq_bit_counter import pattern_seq_pkg::*; #(
  parameter int LEN = DEFAULT_LEN,
  parameter int W = clog2_len(LEN)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         tc
);
  assign tc = (idx == W'(LEN - 1));
  always_ff @(posedge clk) begin
    if (reset || clr) idx <= '0;
    else if (inc) idx <= tc ? '0 : idx + W'(1);
  end
endmodule

// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen: programmable serial bit-pattern generator with loop/one-shot modes, pause and abort.
module pattern_seq_gen import pattern_seq_pkg::*; #(
  parameter int LEN = DEFAULT_LEN,
  parameter logic [LEN-1:0] DEFAULT_PAT = LEN'(8'b1011_0010),
  parameter int LOOP_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic [LEN-1:0]          pattern_in,
  output logic                    y,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(LEN)-1:0]  bit_idx,
  output logic [LOOP_W-1:0]       loop_cnt
);
  localparam int IW = clog2_len(LEN);
  pat_state_t state, state_d;
  logic [LEN-1:0] pat;
  logic [IW-1:0] rev;
  logic mode_q, tc, go, adv, wrap, y_d, done_d;
  assign go = (state == IDLE) && start && !stop;
  assign adv = (state == RUN) && en && !stop;
  assign wrap = adv && tc;
  assign rev = IW'(LEN - 1) - bit_idx;
  seq_bit_counter #(.LEN(LEN), .W(IW)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr((state == IDLE) || stop),
    .inc(adv),
    .idx(bit_idx),
    .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = go ? RUN : IDLE;
    else state_d = (stop || (wrap && mode_q)) ? IDLE : RUN;
  end
  // Output register inputs: y holds while paused, clears on any path out of RUN.
  always_comb begin
    busy = (state == RUN);
    y_d = adv ? pat[rev] : ((state == RUN) && !stop) ? y : 1'b0;
    done_d = wrap && mode_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pat <= DEFAULT_PAT;
      y <= 1'b0;
      done <= 1'b0;
      loop_cnt <= '0;
      mode_q <= 1'b0;
    end else begin
      y <= y_d;
      done <= done_d;
      if ((state == IDLE) && load) pat <= pattern_in;
      if (go) mode_q <= mode;
      if (go) loop_cnt <= '0;
      else if (wrap) loop_cnt <= loop_cnt + LOOP_W'(1);
    end
  end
endmodule

// File: tb/tb_pattern_seq_gen.sv
// tb_pattern_seq_gen: scoreboard bench; a cycle model pushes expected outputs that are popped after each edge.
module tb_pattern_seq_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [7:0] pattern_in = '0;
  logic y, busy, done, y2, busy2, done2;
  logic [2:0] bit_idx, bit_idx2;
  logic [7:0] loop_cnt;
  logic [1:0] loop_cnt2;
  int checks = 0, failures = 0;
  typedef struct {logic y; logic busy; logic done; logic [2:0] idx; logic [7:0] lc; logic [1:0] lc2;} exp_t;
  exp_t sb[$];
  logic m_run, m_y, m_done, m_mode;
  logic [7:0] m_pat, ysh;
  int m_idx, m_loop;

  pattern_seq_gen dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .mode(mode), .load(load),
    .pattern_in(pattern_in), .y(y), .busy(busy), .done(done), .bit_idx(bit_idx), .loop_cnt(loop_cnt)
  );
  pattern_seq_gen #(.LOOP_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .mode(mode), .load(load),
    .pattern_in(pattern_in), .y(y2), .busy(busy2), .done(done2), .bit_idx(bit_idx2), .loop_cnt(loop_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.y = m_y; e.busy = m_run; e.done = m_done; e.idx = 3'(m_idx);
    e.lc = 8'(m_loop); e.lc2 = 2'(m_loop);
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("y", y, e.y);
    check("busy", busy, e.busy);
    check("done", done, e.done);
    check("bit_idx", bit_idx, e.idx);
    check("loop_cnt", loop_cnt, e.lc);
    check("loop_cnt2", loop_cnt2, e.lc2);
    ysh = {ysh[6:0], y};
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; stop = 0; en = 0; load = 0;
    m_run = 0; m_y = 0; m_done = 0; m_mode = 0; m_pat = 8'b1011_0010; m_idx = 0; m_loop = 0;
    push_exp();
    @(posedge clk); #1;
    compare_pop();
    reset = 1'b0;
  endtask

  task automatic step(input logic s, input logic sp, input logic e, input logic m, input logic l, input logic [7:0] pi);
    start = s; stop = sp; en = e; mode = m; load = l; pattern_in = pi;
    m_done = 0;
    if (!m_run) begin
      m_y = 0;
      if (l) m_pat = pi;
      if (s && !sp) begin m_run = 1; m_idx = 0; m_loop = 0; m_mode = m; end
    end else if (sp) begin
      m_run = 0; m_y = 0; m_idx = 0;
    end else if (e) begin
      m_y = m_pat[7 - m_idx];
      if (m_idx == 7) begin
        m_idx = 0; m_loop++;
        if (m_mode) begin m_done = 1; m_run = 0; end
      end else m_idx++;
    end
    push_exp();
    @(posedge clk); #1;
    compare_pop();
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 8'h00);
  endtask

  initial begin
    ysh = '0;
    #1;
    do_reset();
    // one-shot default pattern
    step(1, 0, 1, 1, 0, 8'h00);
    run_en(8);
    check("seq_default", ysh, 8'hB2);
    check("oneshot_done", done, 1);
    step(0, 0, 1, 0, 0, 8'h00);
    check("idle_y0", y, 0);
    // loop mode, 20 enabled edges
    step(1, 0, 1, 0, 0, 8'h00);
    run_en(20);
    check("loop20_cnt", loop_cnt, 2);
    step(0, 1, 0, 0, 0, 8'h00);
    // load in IDLE, then mid-run load ignored
    step(0, 0, 0, 0, 1, 8'hF0);
    step(1, 0, 0, 1, 0, 8'h00);
    run_en(3);
    step(0, 0, 1, 0, 1, 8'h0F);
    run_en(4);
    check("seq_f0", ysh, 8'hF0);
    step(0, 0, 0, 0, 0, 8'h00);
    // reset restores default pattern; pause mid one-shot
    do_reset();
    step(1, 0, 0, 1, 0, 8'h00);
    run_en(3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 8'h00);
    check("pause_y", y, 1);
    check("pause_idx", bit_idx, 3);
    run_en(5);
    check("resume_seq", ysh[4:0], 5'b10010);
    check("resume_done", done, 1);
    step(0, 0, 0, 0, 0, 8'h00);
    // stop at bit_idx 5 in loop mode
    step(1, 0, 0, 0, 0, 8'h00);
    run_en(5);
    check("pre_stop_idx", bit_idx, 5);
    step(0, 1, 1, 0, 0, 8'h00);
    check("stop_busy", busy, 0);
    check("stop_y", y, 0);
    check("stop_idx", bit_idx, 0);
    check("stop_done", done, 0);
    // stop and wrap on same edge in one-shot: no done
    step(1, 0, 0, 1, 0, 8'h00);
    run_en(7);
    step(0, 1, 1, 0, 0, 8'h00);
    check("stop_wrap_done", done, 0);
    check("stop_wrap_loop", loop_cnt, 0);
    // start with stop in IDLE: stays idle; start ignored in RUN
    step(1, 1, 0, 0, 0, 8'h00);
    check("start_stop_idle", busy, 0);
    step(1, 0, 0, 0, 0, 8'h00);
    run_en(2);
    step(1, 0, 1, 1, 0, 8'h00);
    check("no_restart_idx", bit_idx, 3);
    // reset mid-run
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_idx", bit_idx, 0);
    // narrow loop counter wraps 1,2,3,0
    step(1, 0, 0, 0, 0, 8'h00);
    run_en(32);
    check("lc2_wrap", loop_cnt2, 0);
    check("lc_four", loop_cnt, 4);
    check("loop_no_done", done, 0);
    step(0, 1, 0, 0, 0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pattern_seq_gen.md
Name: pattern_seq_gen

Overview:
- Parametrised serial bit-pattern generator. It is the next generation of the single-output `y` free-running FSM block.
- Adds a programmable pattern of LEN bits, run/pause control, loop and one-shot modes, abort, and status outputs.
- Sits as a stimulus/sequence source feeding serial datapaths and sequence detectors in the same design.

Parameters:
- LEN, 8, pattern length in bits (≥2).
- DEFAULT_PAT, 8'b1011_0010, pattern register value after reset (width LEN).
- LOOP_W, 8, width of the completed-loop counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin emitting from bit 0.
- stop  in  1  abort; returns to IDLE.
- en  in  1  advance enable while running; low = pause.
- mode  in  1  0 = loop continuously, 1 = one-shot; sampled at the start edge.
- load  in  1  load pattern_in into the pattern register.
- pattern_in  in  LEN  new pattern, MSB emitted first.
- y  out  1  registered serial output.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a one-shot pass completes.
- bit_idx  out  $clog2(LEN)  index of the next bit to emit.
- loop_cnt  out  LOOP_W  number of completed full passes; wraps modulo 2^LOOP_W.

Behaviour:
- Synchronous, active-high reset: state=IDLE, pat=DEFAULT_PAT, y=0, busy=0, done=0, bit_idx=0, loop_cnt=0, mode_q=0. A reset mid-run abandons the pass immediately.
- Two states: IDLE and RUN. busy = (state==RUN), decoded from state.
- IDLE:
  - y held at 0.
  - start=1 → RUN, bit_idx=0, loop_cnt=0, mode_q<=mode.
  - load=1 → pat<=pattern_in. Load and start on the same edge: the load takes effect first and the new pattern is used.
- RUN, en=1 at an edge:
  - y <= pat[LEN-1-bit_idx].
  - bit_idx increments; first bit visible one cycle after the first enabled RUN edge.
- RUN, en=0: y, bit_idx and loop_cnt hold. Pause may last any number of cycles.
- Wrap, at an enabled edge with bit_idx==LEN-1:
  - bit_idx<=0 and loop_cnt<=loop_cnt+1.
  - mode_q=0: stay in RUN.
  - mode_q=1: done<=1 for one cycle and state<=IDLE. y keeps the last bit for that cycle, then goes to 0 on the next edge.
- stop=1 in RUN → IDLE, y<=0, bit_idx<=0, loop_cnt held, no done.
  - stop and wrap on the same edge: stop wins, no done.
  - stop and start on the same edge: stop wins.
- Ignored inputs:
  - start while in RUN: no restart.
  - load while in RUN: pattern unchanged. The pattern is stable for a whole run.
- done is never asserted in loop mode.
- loop_cnt wraps from 2^LOOP_W-1 to 0 with no flag.

Decomposition:
- Shared package pattern_seq_pkg holds:
  - typedef enum logic {IDLE, RUN} pat_state_t;
  - constant DEFAULT_LEN=8;
  - function clog2_len.
- One natural sub-module, seq_bit_counter: modulo-LEN counter with enable and clear, and a terminal-count output. It drives bit_idx and the wrap condition.

Test Plan:
- Reset, then start with mode=1, en=1 held → y = 1,0,1,1,0,0,1,0 on consecutive cycles; done=1 on the cycle y shows the final 0; busy falls the same edge; loop_cnt=1.
- mode=0, en=1 for 20 enabled edges → pattern repeats 10110010 10110010 1011; loop_cnt=2; done stays 0.
- Load 8'hF0 in IDLE, then start one-shot → y = 1,1,1,1,0,0,0,0. Load 8'h0F mid-run → output unchanged.
- One-shot run, en dropped after 3 bits for 5 cycles → y holds 1, bit_idx holds 3; resume yields 1,0,0,1,0 and done fires.
- stop asserted at bit_idx=5 in loop mode → next cycle busy=0, y=0, bit_idx=0, no done. Reset asserted mid-run → all outputs return to reset values and pat=DEFAULT_PAT.
- LOOP_W=2, loop mode for 4 passes → loop_cnt sequence 1,2,3,0.
